// File: rtl/game_pkg.sv
// Shared definitions for the game tick controller: state encoding, default
// divider ratios and the saturating frame-counter increment.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } game_state_e;

    localparam int DEF_DIV_FAST  = 100000;
    localparam int DEF_GAME_DIV  = 10;
    localparam int DEF_BLINK_DIV = 50;
    localparam int DEF_OVER_LOCK = 2;
    localparam int FRAME_W       = 16;

    function automatic logic [FRAME_W-1:0] sat_inc(input logic [FRAME_W-1:0] v);
        return (v == '1) ? v : v + FRAME_W'(1);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// One stage of the divider chain: counts enable pulses 0..DIV-1 and emits a
// strobe on the enable pulse that completes each period.
module tick_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic srst,
    input  logic enable,
    output logic strobe
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          at_last;

    assign at_last = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (enable) begin
            cnt_d = at_last ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Masked by reset so no strobe escapes while the counter is being cleared.
    assign strobe = enable & at_last & ~srst;

endmodule

// File: rtl/game_tick_ctrl.sv
// Game timing and mode controller: free-running fast/game/blink divider chain
// plus the IDLE/RUN/PAUSE/OVER state machine that gates the game tick.
module game_tick_ctrl
    import game_pkg::*;
#(
    parameter int DIV_FAST  = DEF_DIV_FAST,
    parameter int GAME_DIV  = DEF_GAME_DIV,
    parameter int BLINK_DIV = DEF_BLINK_DIV,
    parameter int OVER_LOCK = DEF_OVER_LOCK
) (
    input  logic               clock_in,
    input  logic               rst,
    input  logic               btn_start,
    input  logic               btn_pause,
    input  logic               collision,
    output logic               tick_fast,
    output logic               tick_game,
    output logic               tick_blink,
    output logic               blink_on,
    output logic [1:0]         state,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int LOCK_W = (OVER_LOCK > 0) ? $clog2(OVER_LOCK + 1) : 1;
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(OVER_LOCK);
    localparam int DIVS [3] = '{DIV_FAST, GAME_DIV, BLINK_DIV};

    // chain[0] is the always-on input; chain[k] is the strobe of stage k.
    logic [3:0] chain;
    logic       tick_game_raw;

    assign chain[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_stage
            tick_prescaler #(
                .DIV (DIVS[gi])
            ) u_div (
                .clk    (clock_in),
                .srst   (rst),
                .enable (chain[gi]),
                .strobe (chain[gi+1])
            );
        end
    endgenerate

    assign tick_fast     = chain[1];
    assign tick_game_raw = chain[2];
    assign tick_blink    = chain[3];

    game_state_e        state_q, state_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [LOCK_W-1:0]  lock_q, lock_d;
    logic               blink_q, blink_d;
    logic [2:0]         btn_q;
    logic               start_edge, pause_edge, coll_edge;

    // btn_q holds last cycle's {collision, pause, start} levels.
    assign start_edge = btn_start & ~btn_q[0];
    assign pause_edge = btn_pause & ~btn_q[1];
    assign coll_edge  = collision & ~btn_q[2];

    assign tick_game = tick_game_raw & (state_q == ST_RUN);

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        lock_d  = lock_q;
        blink_d = blink_q;

        if (tick_game) begin
            frame_d = sat_inc(frame_q);
        end
        if (tick_blink && (lock_q != '0)) begin
            lock_d = lock_q - LOCK_W'(1);
        end
        if (tick_blink) begin
            blink_d = ~blink_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    state_d = ST_RUN;
                    frame_d = '0;
                end
            end
            ST_RUN: begin
                if (coll_edge) begin
                    state_d = ST_OVER;
                    lock_d  = LOCK_LOAD;
                end else if (pause_edge) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (pause_edge) begin
                    state_d = ST_RUN;
                end
            end
            ST_OVER: begin
                if (start_edge && (lock_q == '0)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Blink is pinned high while running and restarts from high on exit.
        if ((state_q == ST_RUN) || (state_d == ST_RUN)) begin
            blink_d = 1'b1;
        end
    end

    always_ff @(posedge clock_in) begin
        if (rst) begin
            state_q <= ST_IDLE;
            frame_q <= '0;
            lock_q  <= '0;
            blink_q <= 1'b1;
            btn_q   <= '0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            lock_q  <= lock_d;
            blink_q <= blink_d;
            btn_q   <= {collision, btn_pause, btn_start};
        end
    end

    assign state     = state_q;
    assign frame_cnt = frame_q;
    assign blink_on  = blink_q;

endmodule

// File: tb/tb_game_tick_ctrl.sv
// Scoreboard bench for game_tick_ctrl: a cycle-level reference model built from
// period arithmetic and mode rules, plus a fast-divider instance for saturation.
module tb_game_tick_ctrl;

    localparam int DF      = 4;
    localparam int GD      = 3;
    localparam int BD      = 2;
    localparam int OL      = 2;
    localparam int P_FAST  = DF;
    localparam int P_GAME  = DF * GD;
    localparam int P_BLINK = DF * GD * BD;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance
    logic        rst, btn_start, btn_pause, collision;
    logic        tick_fast, tick_game, tick_blink, blink_on;
    logic [1:0]  state;
    logic [15:0] frame_cnt;

    game_tick_ctrl #(
        .DIV_FAST  (DF),
        .GAME_DIV  (GD),
        .BLINK_DIV (BD),
        .OVER_LOCK (OL)
    ) dut (
        .clock_in   (clk),
        .rst        (rst),
        .btn_start  (btn_start),
        .btn_pause  (btn_pause),
        .collision  (collision),
        .tick_fast  (tick_fast),
        .tick_game  (tick_game),
        .tick_blink (tick_blink),
        .blink_on   (blink_on),
        .state      (state),
        .frame_cnt  (frame_cnt)
    );

    // Saturation instance: a game tick every cycle, start held high through reset.
    logic        rst2, start2;
    logic        tf2, tg2, tb2, bl2;
    logic [1:0]  st2;
    logic [15:0] fc2;

    game_tick_ctrl #(
        .DIV_FAST  (1),
        .GAME_DIV  (1),
        .BLINK_DIV (4),
        .OVER_LOCK (1)
    ) dut_sat (
        .clock_in   (clk),
        .rst        (rst2),
        .btn_start  (start2),
        .btn_pause  (1'b0),
        .collision  (1'b0),
        .tick_fast  (tf2),
        .tick_game  (tg2),
        .tick_blink (tb2),
        .blink_on   (bl2),
        .state      (st2),
        .frame_cnt  (fc2)
    );

    typedef struct packed {
        logic        tf;
        logic        tg;
        logic        tb;
        logic        bl;
        logic [1:0]  st;
        logic [15:0] fc;
    } obs_t;

    obs_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   done_main = 1'b0;
    bit   done_sat  = 1'b0;

    // Reference model state (registers as they stand after the latest edge)
    bit m_valid = 1'b0;
    int m_n, m_state, m_frame, m_lock;
    bit m_blink, m_ps, m_pp, m_pc;

    function automatic bit fires(input int n, input int period);
        return (n % period) == (period - 1);
    endfunction

    function automatic obs_t expect_now();
        obs_t o;
        bit   live = !rst;
        bit   raw  = live && fires(m_n, P_GAME);
        o.tf = live && fires(m_n, P_FAST);
        o.tb = live && fires(m_n, P_BLINK);
        o.tg = raw && (m_state == 1);
        o.bl = m_blink;
        o.st = m_state[1:0];
        o.fc = m_frame[15:0];
        return o;
    endfunction

    // Apply one clock edge to the model using the inputs currently driven.
    function automatic void model_edge();
        obs_t o = expect_now();
        bit   se, pe, ce;
        int   ns, old_lock;
        if (rst) begin
            m_valid = 1'b1;
            m_n = 0; m_state = 0; m_frame = 0; m_lock = 0;
            m_blink = 1'b1; m_ps = 1'b0; m_pp = 1'b0; m_pc = 1'b0;
            return;
        end
        se = btn_start && !m_ps;
        pe = btn_pause && !m_pp;
        ce = collision && !m_pc;
        ns = m_state;
        old_lock = m_lock;
        if (o.tg) m_frame = (m_frame >= 65535) ? 65535 : m_frame + 1;
        if (o.tb && m_lock > 0) m_lock = m_lock - 1;
        case (m_state)
            0: if (se) begin ns = 1; m_frame = 0; end
            1: if (ce) begin ns = 3; m_lock = OL; end
               else if (pe) ns = 2;
            2: if (pe) ns = 1;
            default: if (se && old_lock == 0) ns = 0;
        endcase
        if (m_state == 1 || ns == 1) m_blink = 1'b1;
        else if (o.tb) m_blink = !m_blink;
        m_state = ns;
        m_n = m_n + 1;
        m_ps = btn_start; m_pp = btn_pause; m_pc = collision;
    endfunction

    // Called 1 time unit after a rising edge: drive, queue expectation, take the edge.
    task automatic cycle(input bit r, input bit s, input bit p, input bit c);
        rst = r; btn_start = s; btn_pause = p; collision = c;
        if (m_valid) exp_q.push_back(expect_now());
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: pops one expectation per presented output cycle
    initial begin : monitor
        int   cyc;
        logic [1:0] last_st;
        obs_t e, a;
        cyc = 0;
        last_st = 2'd0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {tick_fast, tick_game, tick_blink, blink_on, state, frame_cnt};
                tests++;
                if (a !== e) begin
                    fails++;
                    $display("FAIL scoreboard cyc=%0d got tf=%b tg=%b tb=%b bl=%b st=%0d fc=%h want tf=%b tg=%b tb=%b bl=%b st=%0d fc=%h",
                             cyc, a.tf, a.tg, a.tb, a.bl, a.st, a.fc, e.tf, e.tg, e.tb, e.bl, e.st, e.fc);
                end
                if (state !== last_st) begin
                    $display("[TB] cyc=%0d state %0d -> %0d frame=%0d", cyc, last_st, state, frame_cnt);
                    last_st = state;
                end
                cyc++;
            end
        end
    end

    // Main directed + randomized stimulus
    initial begin : stim
        bit s_lvl, p_lvl, c_lvl, r;
        rst = 1'b1; btn_start = 1'b0; btn_pause = 1'b0; collision = 1'b0;
        s_lvl = 1'b0; p_lvl = 1'b0; c_lvl = 1'b0;

        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        $display("[TB] divider chain from reset");
        idle(30);

        $display("[TB] start held high");
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        idle(40);

        $display("[TB] pause for three game periods");
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        idle(12);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        idle(3 * P_GAME - 13);
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        idle(20);

        $display("[TB] pause and collision together, then lockout");
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        idle(2);
        for (int k = 0; k < 6; k++) begin
            idle(14);
            cycle(1'b0, 1'b1, 1'b0, 1'b0);
        end
        idle(5);

        $display("[TB] restart, then reset mid-run");
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        idle(50);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        idle(10);

        $display("[TB] randomized inputs");
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 7) == 0)  s_lvl = ~s_lvl;
            if ($urandom_range(0, 9) == 0)  p_lvl = ~p_lvl;
            if ($urandom_range(0, 39) == 0) c_lvl = ~c_lvl;
            cycle(r, s_lvl, p_lvl, c_lvl);
        end
        idle(2);
        @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        done_main = 1'b1;
    end

    // Saturation run: frame_cnt after the m-th edge since release is min(m-1, 65535)
    initial begin : sat_run
        int want;
        rst2 = 1'b1;
        start2 = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst2 = 1'b0;
        for (int m = 1; m <= 65540; m++) begin
            @(posedge clk);
            #1;
            if (m == 1 || m == 2 || m == 3 || m == 1000 || m == 65534 ||
                m == 65535 || m == 65536 || m == 65537 || m == 65540) begin
                want = (m - 1 > 65535) ? 65535 : m - 1;
                tests++;
                if (fc2 !== want[15:0] || st2 !== 2'd1 || bl2 !== 1'b1 || tg2 !== 1'b1) begin
                    fails++;
                    $display("FAIL saturate m=%0d got fc=%h st=%0d bl=%b tg=%b want fc=%h st=1 bl=1 tg=1",
                             m, fc2, st2, bl2, tg2, want[15:0]);
                end else begin
                    $display("[TB] saturate m=%0d frame=%h", m, fc2);
                end
            end
        end
        done_sat = 1'b1;
    end

    initial begin : finisher
        wait (done_main && done_sat);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
